// File: rtl/hazard_window_pkg.sv
// Shared types for the hazard window: IF/ID control encodings and the
// pending-write slot record.
package hazard_window_pkg;

  // Slot fields are sized for the widest supported configuration. Narrower
  // instances zero-extend into them, so compares stay exact.
  localparam int REG_W_MAX = 8;
  localparam int LAT_W_MAX = 8;

  // IF/ID pipeline register control.
  typedef enum logic [1:0] {
    IF_PASS  = 2'b00,
    IF_HOLD  = 2'b01,
    IF_FLUSH = 2'b10
  } if_ctrl_e;

  // One in-flight producer: destination register and its forwarding latency.
  typedef struct packed {
    logic                 valid;
    logic [REG_W_MAX-1:0] rd;
    logic [LAT_W_MAX-1:0] lat;
  } slot_t;

endpackage

// File: rtl/hazard_match.sv
// Compares one ID source register against every window slot. A slot is a
// hazard while its producer still needs more cycles than it has already aged.
module hazard_match
  import hazard_window_pkg::*;
#(
  parameter int REG_W   = 5,
  parameter int MAX_LAT = 3
) (
  input  logic [REG_W-1:0] src,
  input  slot_t            slots [MAX_LAT],
  output logic             hit
);

  logic [REG_W_MAX-1:0] src_ext;
  logic [MAX_LAT-1:0]   slot_hit;

  assign src_ext = REG_W_MAX'(src);

  // Slot gi was issued gi+1 cycles ago; it blocks while lat exceeds that age.
  // Register 0 is hard-wired, so it can never carry a dependency.
  generate
    for (genvar gi = 0; gi < MAX_LAT; gi++) begin : g_slot
      assign slot_hit[gi] = slots[gi].valid
                          && (slots[gi].rd == src_ext)
                          && (src_ext != '0)
                          && (int'(slots[gi].lat) > gi + 1);
    end
  endgenerate

  assign hit = |slot_hit;

endmodule

// File: rtl/hazard_window.sv
// Pipeline hazard unit: tracks recently issued register writers in a shift
// window, stalls ID consumers until results are forwardable, and applies
// branch-flush priority over stalls. Also counts data-stall cycles.
module hazard_window
  import hazard_window_pkg::*;
#(
  parameter int REG_W   = 5,
  parameter int MAX_LAT = 3,
  parameter int KILL_N  = 1,
  parameter int LAT_W   = $clog2(MAX_LAT + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_read_rs,
  input  logic             id_read_rt,
  input  logic             id_wen,
  input  logic [REG_W-1:0] id_rd,
  input  logic [LAT_W-1:0] id_lat,
  input  logic             br_flush,
  input  logic             perf_clr,
  output logic             pc_stall,
  output logic [1:0]       if_ctrl,
  output logic             id_bubble,
  output logic             exe_flush,
  output logic             data_stall,
  output logic [15:0]      stall_cnt
);

  slot_t                window_reg  [MAX_LAT];
  slot_t                window_next [MAX_LAT];
  logic                 hit_rs;
  logic                 hit_rt;
  logic                 issue;
  logic [LAT_W_MAX-1:0] lat_clamped;
  logic [15:0]          stall_cnt_reg;

  // Latencies beyond the window depth behave the same as the full depth.
  assign lat_clamped = (int'(id_lat) > MAX_LAT) ? LAT_W_MAX'(MAX_LAT)
                                                : LAT_W_MAX'(id_lat);

  // An instruction leaves ID only when it is neither stalled nor squashed.
  assign issue = id_valid & ~data_stall & ~br_flush;

  // Next window: slot0 takes the issuing writer (or a bubble), older slots
  // shift; on a flush the youngest KILL_N producers are dropped in transit.
  generate
    for (genvar gi = 0; gi < MAX_LAT; gi++) begin : g_slot
      if (gi == 0) begin : g_head
        assign window_next[gi] = {issue & id_wen & (id_rd != '0),
                                  REG_W_MAX'(id_rd),
                                  lat_clamped};
      end else begin : g_tail
        localparam bit KILLABLE = ((gi - 1) < KILL_N);
        assign window_next[gi] = {window_reg[gi-1].valid & ~(br_flush & KILLABLE),
                                  window_reg[gi-1].rd,
                                  window_reg[gi-1].lat};
      end
    end
  endgenerate

  // Window register; reset clears every slot so no stale producer survives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < MAX_LAT; k++) window_reg[k] <= '0;
    end else begin
      window_reg <= window_next;
    end
  end

  hazard_match #(
    .REG_W   (REG_W),
    .MAX_LAT (MAX_LAT)
  ) u_match_rs (
    .src   (id_rs),
    .slots (window_reg),
    .hit   (hit_rs)
  );

  hazard_match #(
    .REG_W   (REG_W),
    .MAX_LAT (MAX_LAT)
  ) u_match_rt (
    .src   (id_rt),
    .slots (window_reg),
    .hit   (hit_rt)
  );

  assign data_stall = id_valid & ((id_read_rs & hit_rs) | (id_read_rt & hit_rt));

  // Pipeline control: a taken branch squashes regardless of any data hazard.
  always_comb begin
    pc_stall  = 1'b0;
    if_ctrl   = IF_PASS;
    id_bubble = 1'b0;
    exe_flush = 1'b0;
    if (br_flush) begin
      if_ctrl   = IF_FLUSH;
      id_bubble = 1'b1;
      exe_flush = 1'b1;
    end else if (data_stall) begin
      pc_stall  = 1'b1;
      if_ctrl   = IF_HOLD;
      id_bubble = 1'b1;
    end
  end

  // Saturating count of real stall cycles; a flush cycle is not a stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_reg <= '0;
    end else if (perf_clr) begin
      stall_cnt_reg <= '0;
    end else if (data_stall && !br_flush && (stall_cnt_reg != 16'hFFFF)) begin
      stall_cnt_reg <= stall_cnt_reg + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_reg;

endmodule
